// File: rtl/demux_1to4_stream.sv
// demux_1to4_stream: 1-to-4 stream demux with one valid/ready slot per channel.
// Optional per-channel word counters enabled by defining DEMUX_CNT_EN.
module demux_1to4_stream #(
    parameter int WIDTH = 32
`ifdef DEMUX_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               s0,
    input  logic               s1,
`ifdef DEMUX_CNT_EN
    input  logic               cnt_clr,
    output logic [4*CNT_W-1:0] cnt_flat,
`endif
    output logic [WIDTH-1:0]   y0,
    output logic [WIDTH-1:0]   y1,
    output logic [WIDTH-1:0]   y2,
    output logic [WIDTH-1:0]   y3,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready
);
    logic [1:0]       sel;
    logic             acc;
    logic [3:0]       fill;
    logic [WIDTH-1:0] y [4];

    assign sel      = {s1, s0};
    assign in_ready = ~out_valid[sel] | out_ready[sel];
    assign acc      = in_valid & in_ready;
    assign fill     = {4{acc}} & (4'b0001 << sel);
    assign y0       = y[0];
    assign y1       = y[1];
    assign y2       = y[2];
    assign y3       = y[3];

    // a drain and a fill on the same edge leave the slot valid with the new word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
            for (int k = 0; k < 4; k++) y[k] <= '0;
        end else begin
            out_valid <= (out_valid & ~out_ready) | fill;
            if (acc) y[sel] <= in_data;
        end
    end

`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] cnt [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) cnt[k] <= '0;
        end else begin
            for (int k = 0; k < 4; k++) cnt[k] <= cnt_clr ? '0 : cnt[k] + CNT_W'(fill[k]);
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_cnt
        assign cnt_flat[g*CNT_W +: CNT_W] = cnt[g];
    end
`endif
endmodule

// File: tb/tb_demux_1to4_stream.sv
// tb_demux_1to4_stream: directed + random traffic checked against a slot-array model.
module tb_demux_1to4_stream;
    localparam int W = 32;
`ifdef DEMUX_CNT_EN
    localparam int CW = 16;
    logic            cnt_clr = 0;
    logic [4*CW-1:0] cnt_flat;
    int              mcnt [4] = '{default: 0};
`endif
    logic         clk = 0, rst_n = 0, in_valid = 0, s0 = 0, s1 = 0, in_ready;
    logic [W-1:0] in_data = 0, y0, y1, y2, y3;
    logic [3:0]   out_valid, out_ready = 0;
    int           n_chk = 0, n_fail = 0;

    bit           mv [4] = '{default: 0};
    logic [W-1:0] my [4] = '{default: '0};

    always #5 clk = ~clk;

    demux_1to4_stream #(.WIDTH(W)
`ifdef DEMUX_CNT_EN
        , .CNT_W(CW)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .s0(s0), .s1(s1),
`ifdef DEMUX_CNT_EN
        .cnt_clr(cnt_clr), .cnt_flat(cnt_flat),
`endif
        .y0(y0), .y1(y1), .y2(y2), .y3(y3),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit v, input int s, input logic [W-1:0] d);
        in_valid = v;
        {s1, s0} = 2'(s);
        in_data  = d;
    endtask

    // model: each channel is a one-entry slot; drains happen, then the accepted word lands
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                mv[k] = 0;
                my[k] = '0;
`ifdef DEMUX_CNT_EN
                mcnt[k] = 0;
`endif
            end
        end else begin
            int  s;
            bit  take;
            s    = {s1, s0};
            take = in_valid && (!mv[s] || out_ready[s]);
            for (int k = 0; k < 4; k++) if (mv[k] && out_ready[k]) mv[k] = 0;
            if (take) begin
                mv[s] = 1;
                my[s] = in_data;
            end
`ifdef DEMUX_CNT_EN
            if (cnt_clr) for (int k = 0; k < 4; k++) mcnt[k] = 0;
            else if (take) mcnt[s] = (mcnt[s] + 1) % (1 << CW);
`endif
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            int s;
            s = {s1, s0};
            chk("in_ready", in_ready, (!mv[s] || out_ready[s]));
            chk("out_valid", out_valid, {mv[3], mv[2], mv[1], mv[0]});
            chk("y0", y0, my[0]);
            chk("y1", y1, my[1]);
            chk("y2", y2, my[2]);
            chk("y3", y3, my[3]);
`ifdef DEMUX_CNT_EN
            for (int k = 0; k < 4; k++)
                chk($sformatf("cnt%0d", k), cnt_flat[k*CW +: CW], mcnt[k]);
`endif
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        #1;
        chk("reset out_valid", out_valid, 0);
        chk("reset y0", y0, 0);
        chk("reset y3", y3, 0);
        chk("reset in_ready", in_ready, 1);
`ifdef DEMUX_CNT_EN
        chk("reset cnt_flat", cnt_flat, 0);
`endif
        // 1: single word to ch0 with all consumers ready
        out_ready = 4'hF;
        drive(1, 0, 16778);
        step();
        chk("t1 y0", y0, 16778);
        chk("t1 out_valid", out_valid, 4'b0001);
        drive(0, 0, 0);
        step();
        out_ready = 4'h0;
        // 2: fill all four, then stall on full ch2
        drive(1, 0, 1); step();
        drive(1, 1, 2); step();
        drive(1, 2, 3458578); step();
        drive(1, 3, 4); step();
        drive(0, 0, 0);
        chk("t2 out_valid", out_valid, 4'b1111);
        chk("t2 y0", y0, 1);
        chk("t2 y1", y1, 2);
        chk("t2 y2", y2, 3458578);
        chk("t2 y3", y3, 4);
        drive(1, 2, 99);
        #1 chk("t2 in_ready stall", in_ready, 0);
        step();
        chk("t2 y2 held", y2, 3458578);
        // 3: drain and fill ch1 on the same edge
        out_ready = 4'b0010;
        drive(1, 1, 7);
        #1 chk("t3 in_ready", in_ready, 1);
        step();
        chk("t3 out_valid1", out_valid[1], 1);
        chk("t3 y1", y1, 7);
        drive(0, 0, 0);
        // 4: ch3 stalled does not block a word to ch0
        out_ready = 4'b0001;
        step();
        out_ready = 4'b0000;
        drive(1, 0, 9);
        step();
        drive(0, 0, 0);
        chk("t4 y0", y0, 9);
        chk("t4 out_valid3", out_valid[3], 1);
        chk("t4 y3", y3, 4);
        // 5: async reset with 1011 held
        out_ready = 4'b0100;
        step();
        out_ready = 4'b0000;
        chk("t5 pre out_valid", out_valid, 4'b1011);
        #1 rst_n = 0;
        #1;
        chk("t5 out_valid", out_valid, 0);
        chk("t5 y0", y0, 0);
        chk("t5 y1", y1, 0);
        chk("t5 y3", y3, 0);
        @(posedge clk);
        #2 rst_n = 1;
        #1 chk("t5 in_ready", in_ready, 1);
        // random traffic, checked every cycle by the model
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom), $urandom_range(0, 3), $urandom);
            out_ready = 4'($urandom);
            step();
        end
        drive(0, 0, 0);
        out_ready = 4'h0;
`ifdef DEMUX_CNT_EN
        // 6: counter wrap and clear priority
        cnt_clr = 1;
        step();
        cnt_clr = 0;
        chk("t6 cleared", cnt_flat, 0);
        out_ready = 4'b0100;
        for (int i = 0; i < 65537; i++) begin
            drive(1, 2, i);
            step();
        end
        drive(0, 0, 0);
        chk("t6 ch2 wrap", cnt_flat[2*CW +: CW], 1);
        chk("t6 ch0", cnt_flat[0 +: CW], 0);
        drive(1, 2, 55);
        cnt_clr = 1;
        step();
        cnt_clr = 0;
        drive(0, 0, 0);
        chk("t6 clr priority", cnt_flat[2*CW +: CW], 0);
        chk("t6 clr word y2", y2, 55);
`endif
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
